// File: rtl/cv32e40p_wb_arbiter.sv
// Register-file write-port arbiter between the in-order EX result and out-of-order APU responses.
// APU results that lose arbitration wait in a small in-order buffer that EX can starve only briefly.
module cv32e40p_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_we_i,
    input  logic [5:0]               ex_waddr_i,
    input  logic [31:0]              ex_wdata_i,
    output logic                     ex_stall_o,
    input  logic                     apu_rvalid_i,
    input  logic [5:0]               apu_waddr_i,
    input  logic [31:0]              apu_result_i,
    output logic                     apu_ready_o,
    output logic                     rf_we_o,
    output logic [5:0]               rf_waddr_o,
    output logic [31:0]              rf_wdata_o,
    input  logic [5:0]               chk_addr_i,
    output logic                     chk_hit_o,
    output logic [$clog2(DEPTH):0]   buf_count_o,
    output logic                     ovf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1_C   = CW'(DEPTH - 1);
    localparam logic [3:0]    STARVE_MAX_C = 4'(STARVE_MAX);

    logic [5:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [3:0]    starve_q, starve_d;
    logic          ovf_q, ovf_d;

    logic buf_empty;
    logic buf_full;
    logic force_buf;
    logic buf_win;
    logic ex_win;
    logic bypass;
    logic apu_valid_nz;
    logic push;
    logic pop;

    assign buf_empty    = (count_q == '0);
    assign buf_full     = (count_q == DEPTH_C);
    assign force_buf    = !buf_empty && (buf_full || (starve_q == STARVE_MAX_C));
    assign apu_valid_nz = apu_rvalid_i && (apu_waddr_i != 6'd0);

    // Reset masks every grant so nothing reaches the register file while rst is high.
    assign buf_win = !rst && !buf_empty && (force_buf || !ex_we_i);
    assign ex_win  = !rst && ex_we_i && !force_buf;
    assign bypass  = !rst && buf_empty && !ex_we_i && apu_valid_nz;
    assign pop     = buf_win;
    assign push    = !rst && apu_valid_nz && !bypass && !buf_full;

    assign ex_stall_o  = !rst && ex_we_i && !ex_win;
    assign apu_ready_o = !rst && ((count_q < DEPTH_M1_C) || ((count_q == DEPTH_M1_C) && pop));
    assign buf_count_o = count_q;
    assign ovf_o       = ovf_q;

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 6'd0;
        rf_wdata_o = 32'd0;
        if (buf_win) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = addr_mem[rd_ptr_q];
            rf_wdata_o = data_mem[rd_ptr_q];
        end else if (ex_win) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = ex_waddr_i;
            rf_wdata_o = ex_wdata_i;
        end else if (bypass) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = apu_waddr_i;
            rf_wdata_o = apu_result_i;
        end
    end

    always_comb begin
        count_d  = count_q + CW'(push) - CW'(pop);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        ovf_d    = ovf_q || (apu_rvalid_i && buf_full);
        starve_d = starve_q;
        if (buf_empty || buf_win) begin
            starve_d = 4'd0;
        end else if (ex_win && (starve_q < STARVE_MAX_C)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            starve_q <= 4'd0;
            ovf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            starve_q <= starve_d;
            ovf_q    <= ovf_d;
        end
    end

    // Payload storage is never reset; validity comes from the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= apu_waddr_i;
            data_mem[wr_ptr_q] <= apu_result_i;
        end
    end

    logic [DEPTH-1:0] entry_hit;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_chk
        logic [PW-1:0] offset;
        assign offset        = PW'(gi) - rd_ptr_q;
        assign entry_hit[gi] = ({1'b0, offset} < count_q) && (addr_mem[gi] == chk_addr_i);
    end

    assign chk_hit_o = (chk_addr_i != 6'd0) &&
                       ((|entry_hit) || (apu_rvalid_i && (apu_waddr_i == chk_addr_i)));

endmodule
